// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and writeback.
// The master modport is the ALU/writeback side; the slave modport is the stage.
interface alu_result_stage_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    FS;
    logic [DW-1:0] Y_hi;
    logic [DW-1:0] Y_lo;
    logic          N;
    logic          Z;
    logic          V;
    logic          C;
    logic          hilo_ld;
    logic [1:0]    src_sel;
    logic          flg_ld;
    logic          ovf_clr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] RES_OUT;
    logic [4:0]    RES_FS;

    modport master (
        output in_valid, FS, Y_hi, Y_lo, N, Z, V, C,
        output hilo_ld, src_sel, flg_ld, ovf_clr, out_ready,
        input  in_ready, out_valid, RES_OUT, RES_FS
    );

    modport slave (
        input  in_valid, FS, Y_hi, Y_lo, N, Z, V, C,
        input  hilo_ld, src_sel, flg_ld, ovf_clr, out_ready,
        output in_ready, out_valid, RES_OUT, RES_FS
    );
endinterface

// File: rtl/alu_result_stage.sv
// Single-entry pipeline register behind the ALU: captures the result word,
// owns the architectural HI/LO pair, the NZVC flags and a sticky overflow bit.
module alu_result_stage #(
    parameter int          DW       = 32,
    parameter logic [DW-1:0] HILO_RST = '0
) (
    input  logic            clk,
    input  logic            reset,
    alu_result_stage_if.slave bus,
    output logic [DW-1:0]   HI,
    output logic [DW-1:0]   LO,
    output logic [3:0]      FLAGS,
    output logic            OVF_STK
);
    logic          r_out_valid;
    logic [DW-1:0] r_res;
    logic [4:0]    r_fs;
    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;
    logic [3:0]    r_flags;
    logic          r_ovf;

    logic          w_in_ready;
    logic          w_accept;
    logic [DW-1:0] w_res_sel;

    // The slot frees up in the same cycle writeback consumes it, so no bubble.
    assign w_in_ready = !r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;

    // MFHI/MFLO see the pre-edge HI/LO; a same-op hilo_ld is not forwarded.
    always_comb begin
        w_res_sel = bus.Y_lo;
        case (bus.src_sel)
            2'b01:   w_res_sel = r_hi;
            2'b10:   w_res_sel = r_lo;
            default: w_res_sel = bus.Y_lo;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_fs        <= '0;
            r_hi        <= HILO_RST;
            r_lo        <= HILO_RST;
            r_flags     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= w_accept | (r_out_valid & !bus.out_ready);
            r_ovf       <= (r_ovf & !bus.ovf_clr) | (w_accept & bus.flg_ld & bus.V);
            if (w_accept) begin
                r_res <= w_res_sel;
                r_fs  <= bus.FS;
                if (bus.hilo_ld) begin
                    r_hi <= bus.Y_hi;
                    r_lo <= bus.Y_lo;
                end
                if (bus.flg_ld) begin
                    r_flags <= {bus.N, bus.Z, bus.V, bus.C};
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.RES_OUT   = r_res;
    assign bus.RES_FS    = r_fs;
    assign HI            = r_hi;
    assign LO            = r_lo;
    assign FLAGS         = r_flags;
    assign OVF_STK       = r_ovf;
endmodule

// File: tb/tb_alu_result_stage.sv
// Randomised and directed bench for alu_result_stage against a queue-based
// reference of the result slot plus plain HI/LO/flag bookkeeping.
module tb_alu_result_stage;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_result_stage_if #(.DW(DW)) bus ();
    logic [DW-1:0] HI;
    logic [DW-1:0] LO;
    logic [3:0]    FLAGS;
    logic          OVF_STK;

    alu_result_stage #(.DW(DW), .HILO_RST('0)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .HI      (HI),
        .LO      (LO),
        .FLAGS   (FLAGS),
        .OVF_STK (OVF_STK)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: results waiting for writeback, last captured word, arch regs.
    logic [DW+4:0] q[$];
    logic [DW-1:0] m_res, m_hi, m_lo;
    logic [4:0]    m_fs;
    logic [3:0]    m_flags;
    logic          m_ovf;

    task automatic model_reset();
        q.delete();
        m_res = '0; m_fs = '0; m_hi = '0; m_lo = '0; m_flags = '0; m_ovf = 1'b0;
    endtask

    task automatic model_edge();
        bit rdy, acc;
        logic [DW-1:0] sel;
        logic [DW+4:0] tmp;
        rdy = (q.size() == 0) || bus.out_ready;
        acc = bus.in_valid && rdy;
        case (bus.src_sel)
            2'b01:   sel = m_hi;
            2'b10:   sel = m_lo;
            default: sel = bus.Y_lo;
        endcase
        if (q.size() != 0 && bus.out_ready) tmp = q.pop_front();
        if (acc) begin
            q.push_back({bus.FS, sel});
            m_res = sel;
            m_fs  = bus.FS;
        end
        m_ovf = (m_ovf && !bus.ovf_clr) || (acc && bus.flg_ld && bus.V);
        if (acc && bus.hilo_ld) begin
            m_hi = bus.Y_hi;
            m_lo = bus.Y_lo;
        end
        if (acc && bus.flg_ld) m_flags = {bus.N, bus.Z, bus.V, bus.C};
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] fs, input logic [DW-1:0] yhi,
                         input logic [DW-1:0] ylo, input logic [3:0] nzvc, input logic hl,
                         input logic [1:0] src, input logic fl, input logic oc, input logic ordy);
        bus.in_valid = v;   bus.FS = fs;   bus.Y_hi = yhi; bus.Y_lo = ylo;
        {bus.N, bus.Z, bus.V, bus.C} = nzvc;
        bus.hilo_ld = hl;   bus.src_sel = src; bus.flg_ld = fl; bus.ovf_clr = oc;
        bus.out_ready = ordy;
    endtask

    task automatic test_reset();
        drive(1'b1, 5'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        model_reset();
        @(posedge clk); #1;
        n_total++;
        if ({bus.out_valid, bus.RES_OUT, bus.RES_FS, HI, LO, FLAGS, OVF_STK} !== '0)
            $display("FAIL reset_state: got v=%b res=%h fs=%h hi=%h lo=%h fl=%h ovf=%b expected all zero",
                     bus.out_valid, bus.RES_OUT, bus.RES_FS, HI, LO, FLAGS, OVF_STK);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
        drive(1'b0, 5'h0, '0, '0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_mult_mfhi();
        drive(1'b1, 5'h1E, 32'h1, 32'h2, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        $display("MULT FS=1E hi=%h lo=%h", HI, LO);
        n_total++;
        if (HI !== 32'h1 || LO !== 32'h2) $display("FAIL mult_hilo: got %h/%h expected 1/2", HI, LO);
        else n_pass++;
        drive(1'b1, 5'h10, 32'h77, 32'h99, 4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
        tick();
        $display("MFHI res=%h", bus.RES_OUT);
        n_total++;
        if (bus.RES_OUT !== 32'h1 || bus.out_valid !== 1'b1)
            $display("FAIL mfhi: got %h v=%b expected 00000001 v=1", bus.RES_OUT, bus.out_valid);
        else n_pass++;
        drive(1'b1, 5'h12, 32'h77, 32'h99, 4'h0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        tick();
        $display("MFLO res=%h fs=%h", bus.RES_OUT, bus.RES_FS);
        n_total++;
        if (bus.RES_OUT !== 32'h2 || bus.RES_FS !== 5'h12)
            $display("FAIL mflo: got %h fs=%h expected 00000002 fs=12", bus.RES_OUT, bus.RES_FS);
        else n_pass++;
    endtask

    task automatic test_hilo_same_op();
        drive(1'b1, 5'h1E, 32'hA, 32'h5, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 5'h1E, 32'hB, 32'h6, 4'h0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        tick();
        $display("hilo_ld+MFHI res=%h hi=%h", bus.RES_OUT, HI);
        n_total++;
        if (bus.RES_OUT !== 32'hA) $display("FAIL same_op_res: got %h expected 0000000a", bus.RES_OUT);
        else n_pass++;
        n_total++;
        if (HI !== 32'hB || LO !== 32'h6) $display("FAIL same_op_hilo: got %h/%h expected b/6", HI, LO);
        else n_pass++;
        // Divide-by-zero still writes HI/LO.
        drive(1'b1, 5'h1F, 32'hDEAD, 32'hBEEF, 4'b0100, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        n_total++;
        if (HI !== 32'hDEAD || LO !== 32'hBEEF) $display("FAIL div0_hilo: got %h/%h expected dead/beef", HI, LO);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        drive(1'b0, 5'h0, '0, '0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 5'h03, '0, 32'h1111_0001, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'h04, '0, 32'h2222_0002, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
            else n_pass++;
            n_total++;
            if (bus.RES_OUT !== 32'h1111_0001 || bus.RES_FS !== 5'h03 || bus.out_valid !== 1'b1)
                $display("FAIL stall_hold[%0d]: got %h fs=%h v=%b expected 11110001 fs=03 v=1",
                         i, bus.RES_OUT, bus.RES_FS, bus.out_valid);
            else n_pass++;
            $display("stall cycle %0d res=%h", i, bus.RES_OUT);
            if (i < 2) tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL drain_in_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
        tick();
        $display("drain+accept res=%h", bus.RES_OUT);
        n_total++;
        if (bus.RES_OUT !== 32'h2222_0002 || bus.out_valid !== 1'b1)
            $display("FAIL drain_accept: got %h v=%b expected 22220002 v=1", bus.RES_OUT, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_ovf();
        drive(1'b1, 5'h01, '0, 32'h7, 4'b0010, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        tick();
        $display("V with ovf_clr: ovf=%b flags=%b", OVF_STK, FLAGS);
        n_total++;
        if (OVF_STK !== 1'b1 || FLAGS !== 4'b0010)
            $display("FAIL ovf_set_wins: got ovf=%b flags=%b expected 1/0010", OVF_STK, FLAGS);
        else n_pass++;
        drive(1'b0, 5'h01, '0, '0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        tick();
        $display("ovf_clr alone: ovf=%b", OVF_STK);
        n_total++;
        if (OVF_STK !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", OVF_STK);
        else n_pass++;
    endtask

    task automatic test_idle();
        logic [DW-1:0] hi0, lo0, res0;
        logic [3:0]    fl0;
        hi0 = m_hi; lo0 = m_lo; fl0 = m_flags; res0 = m_res;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 5'($urandom), 32'($urandom), 32'($urandom), 4'hF, 1'b1, 2'($urandom), 1'b1, 1'b0, 1'b1);
            tick();
            $display("idle cycle %0d hi=%h lo=%h flags=%b", i, HI, LO, FLAGS);
            n_total++;
            if (HI !== hi0 || LO !== lo0 || FLAGS !== fl0 || bus.RES_OUT !== res0 || bus.out_valid !== 1'b0)
                $display("FAIL idle[%0d]: got %h/%h/%b/%h v=%b expected %h/%h/%b/%h v=0",
                         i, HI, LO, FLAGS, bus.RES_OUT, bus.out_valid, hi0, lo0, fl0, res0);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 32'($urandom), 32'($urandom),
                  4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
            #1;
            n_total++;
            if (bus.in_ready !== ((q.size() == 0) || bus.out_ready))
                $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, bus.in_ready,
                         (q.size() == 0) || bus.out_ready);
            else n_pass++;
            tick();
            n_total++;
            if (bus.out_valid !== (q.size() != 0) || bus.RES_OUT !== m_res || bus.RES_FS !== m_fs ||
                HI !== m_hi || LO !== m_lo || FLAGS !== m_flags || OVF_STK !== m_ovf)
                $display("FAIL rand_state[%0d]: got v=%b res=%h fs=%h hi=%h lo=%h fl=%b ovf=%b expected v=%b res=%h fs=%h hi=%h lo=%h fl=%b ovf=%b",
                         i, bus.out_valid, bus.RES_OUT, bus.RES_FS, HI, LO, FLAGS, OVF_STK,
                         q.size() != 0, m_res, m_fs, m_hi, m_lo, m_flags, m_ovf);
            else n_pass++;
            if (i % 50 == 0) $display("random op %0d res=%h hi=%h", i, bus.RES_OUT, HI);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 5'h1E, 32'h1234, 32'h5678, 4'b0010, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        model_reset();
        $display("midstream reset v=%b res=%h hi=%h", bus.out_valid, bus.RES_OUT, HI);
        n_total++;
        if ({bus.out_valid, bus.RES_OUT, bus.RES_FS, HI, LO, FLAGS, OVF_STK} !== '0)
            $display("FAIL midreset_state: got v=%b res=%h fs=%h hi=%h lo=%h fl=%h ovf=%b expected all zero",
                     bus.out_valid, bus.RES_OUT, bus.RES_FS, HI, LO, FLAGS, OVF_STK);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
        drive(1'b0, 5'h0, '0, '0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mult_mfhi();
        test_hilo_same_op();
        test_backpressure();
        test_ovf();
        test_idle();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
